picomem_wb_bridge: RTL

- PicoMem slave to Wishbone B4 classic master bridge, one transaction at a time.
- Occupies the 0xC000_0000 slot of the top-level 1:4 PicoMem mux, which is currently tied off.
- Converts each PicoMem valid/ready access into one registered Wishbone cycle.
- Returns read data, or a fixed error word on bus error or timeout.

---
 rtl/picomem_pkg.sv | 23 ++
 rtl/picomem_wb_timeout.sv | 44 ++++
 rtl/picomem_wb_bridge.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/picomem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : picomem_pkg
// Purpose  : Shared definitions for the PicoMem-to-Wishbone bridge: FSM state
//            encoding, the PicoMem "read" strobe value and the default word
//            returned on errored or timed-out accesses.
// Revision : 1.0 - initial release
// ============================================================================
package picomem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // A PicoMem access with all strobes low is a read.
    localparam logic [3:0]  WSTRB_READ        = 4'h0;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/picomem_wb_timeout.sv
`default_nettype none
// ============================================================================
// Module   : picomem_wb_timeout
// Purpose  : Bus-phase watchdog for picomem_wb_bridge. Counts cycles spent in
//            the Wishbone phase and flags the final permitted cycle.
//            Only compiled when PICOMEM_WB_TIMEOUT_EN is defined.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            i_start       - transaction accepted; count restarts from zero
//            i_busy        - bridge is in its Wishbone phase this cycle
//            o_expired     - this is the last allowed Wishbone cycle
// Revision : 1.0 - initial release
// ============================================================================
`ifdef PICOMEM_WB_TIMEOUT_EN
module picomem_wb_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_busy,
    output logic o_expired
);

    localparam int             CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  c_last = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= '0;
        end else if (i_busy && (r_count != c_last)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Expiry is qualified by busy so a stale count in IDLE/RESP never fires.
    assign o_expired = i_busy && (r_count == c_last);

endmodule
`endif
`default_nettype wire

// File: rtl/picomem_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : picomem_wb_bridge
// Purpose  : PicoMem slave to Wishbone B4 classic master bridge. Each PicoMem
//            valid/ready access becomes exactly one registered Wishbone cycle;
//            one transaction outstanding at a time.
// Config   : `define PICOMEM_WB_TIMEOUT_EN to add a bus-phase watchdog that
//            forces an error completion after TIMEOUT_CYCLES Wishbone cycles.
//            Without it the bridge waits indefinitely for ack/err.
// Ports    : clk, rst               - clock, asynchronous active-high reset
//            mem_s_valid/ready      - PicoMem handshake (ready = 1-cycle pulse)
//            mem_s_addr/wdata/wstrb - PicoMem request (wstrb==0 means read)
//            mem_s_rdata            - read data, held until next completion
//            wb_cyc_o/stb_o/we_o    - Wishbone cycle control
//            wb_adr_o/sel_o/dat_o   - Wishbone word address, selects, data
//            wb_dat_i/ack_i/err_i   - Wishbone slave response
//            bus_err                - sticky error flag, cleared only by rst
// Revision : 1.0 - initial release
// ============================================================================
module picomem_wb_bridge
    import picomem_pkg::*;
#(
    parameter int          WB_ADR_W       = 30,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    // PicoMem slave
    input  logic                mem_s_valid,
    output logic                mem_s_ready,
    input  logic [31:0]         mem_s_addr,
    input  logic [31:0]         mem_s_wdata,
    input  logic [3:0]          mem_s_wstrb,
    output logic [31:0]         mem_s_rdata,
    // Wishbone master
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [3:0]          wb_sel_o,
    output logic [31:0]         wb_dat_o,
    input  logic [31:0]         wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    // Status
    output logic                bus_err
);

    state_t r_state;
    state_t w_next_state;

    logic   w_accept;    // request sampled in IDLE this cycle
    logic   w_term;      // Wishbone cycle terminates at this edge
    logic   w_fail;      // termination is an error (err or timeout)
    logic   w_timeout;   // watchdog says this is the last allowed cycle
    logic   w_is_read;

    assign w_is_read = (mem_s_wstrb == WSTRB_READ);

    // Byte-offset bits and any address bits above the word-address window
    // are intentionally dropped.
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, mem_s_addr};

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef PICOMEM_WB_TIMEOUT_EN
    picomem_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_accept),
        .i_busy    (r_state == BUS),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign w_timeout            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and termination decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_term       = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_s_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = BUS;
                end
            end
            BUS: begin
                // Slave response only counts while the strobe is actually out.
                // err beats ack; a real ack/err beats the watchdog.
                if (wb_cyc_o && wb_stb_o) begin
                    w_term = wb_err_i | wb_ack_i | w_timeout;
                    w_fail = wb_err_i | (~wb_ack_i & w_timeout);
                end
                if (w_term) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                // valid is still high here; it is deliberately not sampled.
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign mem_s_ready = (r_state == RESP);

    // ------------------------------------------------------------------
    // Datapath: Wishbone request registers, response capture, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_sel_o    <= 4'h0;
            wb_dat_o    <= 32'h0;
            mem_s_rdata <= 32'h0;
            bus_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                // Request is latched here; later changes on mem_s_* are ignored.
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= ~w_is_read;
                wb_adr_o <= mem_s_addr[WB_ADR_W+1:2];
                wb_sel_o <= w_is_read ? 4'hF : mem_s_wstrb;
                wb_dat_o <= mem_s_wdata;
            end
            if (w_term) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                if (w_fail) begin
                    mem_s_rdata <= ERR_RDATA;
                    bus_err     <= 1'b1;
                end else if (wb_we_o) begin
                    mem_s_rdata <= 32'h0;
                end else begin
                    mem_s_rdata <= wb_dat_i;
                end
            end
        end
    end

endmodule
`default_nettype wire
